regfile_scoreboard: RTL and testbench

REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

---
 rtl/regfile_pkg.sv | 13 +
 rtl/regfile_rdport.sv | 42 ++++
 rtl/regfile_scoreboard.sv | 83 ++++++++
 tb/tb_regfile_scoreboard.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the register file / scoreboard slice.
// Default geometry plus the XZR index helper.
package regfile_pkg;

  localparam int WIDTH_D = 64;
  localparam int DEPTH_D = 32;
  localparam int NREAD_D = 2;

  function automatic int xzr_idx(input int depth);
    return depth - 1;
  endfunction

endpackage

// File: rtl/regfile_rdport.sv
// One combinational read port: index mux, write-through bypass, busy lookup.
// Ports: reset, wr_en/wr_addr/wr_data (qualified writeback), regs, busy, rd_addr -> rd_data, rd_busy.
module regfile_rdport
  import regfile_pkg::*;
#(
  parameter int WIDTH = WIDTH_D,
  parameter int DEPTH = DEPTH_D,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                        reset,
  input  logic                        wr_en,
  input  logic [AW-1:0]               wr_addr,
  input  logic [WIDTH-1:0]            wr_data,
  input  logic [DEPTH-1:0][WIDTH-1:0] regs,
  input  logic [DEPTH-1:0]            busy,
  input  logic [AW-1:0]               rd_addr,
  output logic [WIDTH-1:0]            rd_data,
  output logic                        rd_busy
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW:0] XZR_W   = (AW+1)'(xzr_idx(DEPTH));

  logic ok;
  logic hit;

  assign ok  = ({1'b0, rd_addr} < DEPTH_W) &&
               ({1'b0, rd_addr} != XZR_W);
  // wr_en is already qualified as a writable index
  assign hit = wr_en && (wr_addr == rd_addr);

  always_comb begin
    rd_data = '0;
    rd_busy = 1'b0;
    if (!reset && ok) begin
      rd_data = hit ? wr_data : regs[rd_addr];
      // a writeback in flight counts as available
      rd_busy = busy[rd_addr] && !hit;
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with XZR, async-reset storage and a per-register busy scoreboard.
// Ports: clk, reset, wr_*, iss_*, rd_addr -> rd_data, rd_busy, busy_count.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int WIDTH = WIDTH_D,
  parameter int DEPTH = DEPTH_D,
  parameter int NREAD = NREAD_D,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        wr_en,
  input  logic [AW-1:0]               wr_addr,
  input  logic [WIDTH-1:0]            wr_data,
  input  logic                        iss_en,
  input  logic [AW-1:0]               iss_addr,
  input  logic [NREAD-1:0][AW-1:0]    rd_addr,
  output logic [NREAD-1:0][WIDTH-1:0] rd_data,
  output logic [NREAD-1:0]            rd_busy,
  output logic [CW-1:0]               busy_count
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW:0] XZR_W   = (AW+1)'(xzr_idx(DEPTH));

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [DEPTH-1:0]            busy;
  logic [DEPTH-1:0]            busy_nxt;
  logic                        wr_ok;
  logic                        iss_ok;

  assign wr_ok  = wr_en &&
                  ({1'b0, wr_addr} < DEPTH_W) &&
                  ({1'b0, wr_addr} != XZR_W);
  assign iss_ok = iss_en &&
                  ({1'b0, iss_addr} < DEPTH_W) &&
                  ({1'b0, iss_addr} != XZR_W);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem <= '0;
    end else if (wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // set after clear: a newer producer wins
  always_comb begin
    busy_nxt = busy;
    if (wr_ok)  busy_nxt[wr_addr]  = 1'b0;
    if (iss_ok) busy_nxt[iss_addr] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy       <= '0;
      busy_count <= '0;
    end else begin
      busy       <= busy_nxt;
      busy_count <= CW'($countones(busy_nxt));
    end
  end

  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    regfile_rdport #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_rd (
      .reset   (reset),
      .wr_en   (wr_ok),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .regs    (mem),
      .busy    (busy),
      .rd_addr (rd_addr[k]),
      .rd_data (rd_data[k]),
      .rd_busy (rd_busy[k])
    );
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench for regfile_scoreboard: default build plus a 32x16x3 build.
// Stimulus queues expected values; a negedge monitor pops and compares.
module tb_regfile_scoreboard;

  logic clk = 1'b0;
  logic reset;

  logic            wr_en, iss_en;
  logic [4:0]      wr_addr, iss_addr;
  logic [63:0]     wr_data;
  logic [1:0][4:0]  rd_addr;
  logic [1:0][63:0] rd_data;
  logic [1:0]       rd_busy;
  logic [5:0]       busy_count;

  logic            wr_en2, iss_en2;
  logic [3:0]      wr_addr2, iss_addr2;
  logic [31:0]     wr_data2;
  logic [2:0][3:0]  rd_addr2;
  logic [2:0][31:0] rd_data2;
  logic [2:0]       rd_busy2;
  logic [4:0]       busy_count2;

  always #5 clk = ~clk;

  regfile_scoreboard dut (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .iss_en     (iss_en),
    .iss_addr   (iss_addr),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_busy    (rd_busy),
    .busy_count (busy_count)
  );

  regfile_scoreboard #(
    .WIDTH (32),
    .DEPTH (16),
    .NREAD (3)
  ) dut2 (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en2),
    .wr_addr    (wr_addr2),
    .wr_data    (wr_data2),
    .iss_en     (iss_en2),
    .iss_addr   (iss_addr2),
    .rd_addr    (rd_addr2),
    .rd_data    (rd_data2),
    .rd_busy    (rd_busy2),
    .busy_count (busy_count2)
  );

  typedef struct {
    string       name;
    int          sel;
    int          port;
    logic [63:0] exp;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic expect_v(input string name, input int sel,
                          input int port, input logic [63:0] v);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.port = port;
    e.exp  = v;
    q.push_back(e);
  endtask

  task automatic check_now(input string name,
                           input logic [63:0] act,
                           input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t        e;
      logic [63:0] act;
      e = q.pop_front();
      case (e.sel)
        0:       act = rd_data[e.port];
        1:       act = 64'(rd_busy[e.port]);
        2:       act = 64'(busy_count);
        3:       act = 64'(rd_data2[e.port]);
        default: act = 64'(busy_count2);
      endcase
      n_chk++;
      if (act !== e.exp) begin
        n_fail++;
        $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, act, e.exp);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    wr_en  = 1'b0;
    iss_en = 1'b0;
  endtask

  initial begin
    int w;
    reset = 1'b1;
    idle();
    wr_addr = '0; wr_data = '0; iss_addr = '0;
    rd_addr[0] = 5'd1; rd_addr[1] = 5'd2;
    wr_en2 = 1'b0; iss_en2 = 1'b0;
    wr_addr2 = '0; wr_data2 = '0; iss_addr2 = '0;
    rd_addr2[0] = 4'd3; rd_addr2[1] = 4'd15; rd_addr2[2] = 4'd3;
    #1;
    check_now("rst_cnt_now", 64'(busy_count), 64'h0);
    wr_en = 1'b1; wr_addr = 5'd1; wr_data = 64'hDEAD;
    iss_en = 1'b1; iss_addr = 5'd2;
    expect_v("rst_rd0", 0, 0, 64'h0);
    expect_v("rst_busy1", 1, 1, 64'h0);
    expect_v("rst_cnt", 2, 0, 64'h0);
    tick();
    tick();
    reset = 1'b0;
    idle();
    expect_v("post_rst_rd0", 0, 0, 64'h0);
    expect_v("post_rst_busy1", 1, 1, 64'h0);
    expect_v("post_rst_cnt", 2, 0, 64'h0);

    tick();
    wr_en = 1'b1; wr_addr = 5'd1; wr_data = 64'h1_0000_0000;
    expect_v("x1_bypass", 0, 0, 64'h1_0000_0000);
    expect_v("x1_busy", 1, 0, 64'h0);
    tick();
    idle();
    expect_v("x1_read", 0, 0, 64'h1_0000_0000);
    expect_v("x1_cnt", 2, 0, 64'h0);

    tick();
    wr_en = 1'b1; wr_addr = 5'd31; wr_data = 64'hFFFF;
    rd_addr[0] = 5'd31;
    expect_v("xzr_bypass", 0, 0, 64'h0);
    expect_v("xzr_busy", 1, 0, 64'h0);
    tick();
    idle();
    expect_v("xzr_read", 0, 0, 64'h0);
    expect_v("xzr_cnt", 2, 0, 64'h0);

    tick();
    iss_en = 1'b1; iss_addr = 5'd5; rd_addr[0] = 5'd5;
    expect_v("x5_iss_busy", 1, 0, 64'h0);
    expect_v("x5_iss_cnt", 2, 0, 64'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      idle();
      expect_v("x5_busy", 1, 0, 64'h1);
      expect_v("x5_cnt", 2, 0, 64'h1);
    end
    tick();
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 64'hAB;
    expect_v("x5_wb_busy", 1, 0, 64'h0);
    expect_v("x5_wb_data", 0, 0, 64'hAB);
    expect_v("x5_wb_cnt", 2, 0, 64'h1);
    tick();
    idle();
    w = 0;
    while (busy_count !== '0 && w < 4) begin
      @(posedge clk);
      #1;
      w++;
    end
    check_now("x5_wait_expired", 64'(w < 4), 64'h1);
    expect_v("x5_done_cnt", 2, 0, 64'h0);
    expect_v("x5_done_busy", 1, 0, 64'h0);
    expect_v("x5_done_data", 0, 0, 64'hAB);

    tick();
    iss_en = 1'b1; iss_addr = 5'd7; rd_addr[1] = 5'd7;
    tick();
    idle();
    expect_v("x7_busy", 1, 1, 64'h1);
    expect_v("x7_cnt", 2, 0, 64'h1);
    tick();
    iss_en = 1'b1; iss_addr = 5'd7;
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 64'h77;
    expect_v("x7_both_busy", 1, 1, 64'h0);
    expect_v("x7_both_data", 0, 1, 64'h77);
    tick();
    idle();
    expect_v("x7_set_wins", 1, 1, 64'h1);
    expect_v("x7_data", 0, 1, 64'h77);
    expect_v("x7_cnt_same", 2, 0, 64'h1);
    tick();
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 64'h78;
    tick();
    idle();
    expect_v("x7_clear_cnt", 2, 0, 64'h0);
    expect_v("x7_clear_busy", 1, 1, 64'h0);
    expect_v("x7_clear_data", 0, 1, 64'h78);

    for (int i = 0; i < 31; i++) begin
      tick();
      iss_en = 1'b1; iss_addr = 5'(i);
    end
    tick();
    idle();
    rd_addr[0] = 5'd0; rd_addr[1] = 5'd30;
    expect_v("all_cnt", 2, 0, 64'd31);
    expect_v("all_busy0", 1, 0, 64'h1);
    expect_v("all_busy30", 1, 1, 64'h1);
    tick();
    rd_addr[0] = 5'd1; rd_addr[1] = 5'd5;
    #1;
    reset = 1'b1;
    expect_v("mid_rst_cnt", 2, 0, 64'h0);
    expect_v("mid_rst_rd0", 0, 0, 64'h0);
    expect_v("mid_rst_rd1", 0, 1, 64'h0);
    expect_v("mid_rst_busy1", 1, 1, 64'h0);
    tick();
    reset = 1'b0;
    expect_v("after_rst_cnt", 2, 0, 64'h0);
    expect_v("after_rst_busy", 1, 1, 64'h0);
    expect_v("after_rst_rd0", 0, 0, 64'h0);

    tick();
    wr_en2 = 1'b1; wr_addr2 = 4'd3; wr_data2 = 32'h5;
    expect_v("p_byp0", 3, 0, 64'h5);
    expect_v("p_byp1", 3, 1, 64'h0);
    expect_v("p_byp2", 3, 2, 64'h5);
    tick();
    wr_en2 = 1'b1; wr_addr2 = 4'd15; wr_data2 = 32'hFFFF;
    expect_v("p_rd0", 3, 0, 64'h5);
    expect_v("p_rd1_xzr", 3, 1, 64'h0);
    expect_v("p_rd2", 3, 2, 64'h5);
    tick();
    wr_en2 = 1'b0;
    expect_v("p_xzr_after", 3, 1, 64'h0);
    expect_v("p_cnt", 4, 0, 64'h0);

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
